seq_alu: RTL

- Parametrised, handshaked multi-cycle ALU for the EX stage.
- Keeps the existing opcode map: ADD, SUB, MOVE, SWAP, AND, OR.
- Adds iterative signed MUL and DIV, correct two's-complement overflow detection, and valid/ready flow control on both sides.
- The pipeline control stalls EX on in_ready and out_valid.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Handshake and operand bus for the multi-cycle EX-stage ALU.
// The producer/consumer side uses the master modport, the ALU the slave modport.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [2:0]         alu_control;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               overflow;

  modport master (
    output in_valid, op1, op2, alu_control, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, op1, op2, alu_control, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle logic/add ops plus iterative signed
// MUL (shift-add on magnitudes) and DIV (restoring on magnitudes), sign-fixed at the end.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000, OP_SUB = 3'b001, OP_MOVE = 3'b010, OP_SWAP = 3'b011,
    OP_AND  = 3'b100, OP_OR  = 3'b101, OP_MUL  = 3'b110, OP_DIV  = 3'b111
  } op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_mul_q, is_mul_d;
  logic             neg_quo_q, neg_quo_d;   // product / quotient negative
  logic             neg_rem_q, neg_rem_d;   // remainder follows dividend sign
  logic [W2-1:0]    acc_q, acc_d;           // MUL partial product, DIV remainder
  logic [W2-1:0]    x_q, x_d;               // MUL shifted multiplicand, DIV dividend/quotient
  logic [WIDTH-1:0] y_q, y_d;               // MUL multiplier, DIV divisor magnitude
  logic [W2-1:0]    result_q, result_d;
  logic             overflow_q, overflow_d;

  op_e              op_in;
  logic [WIDTH-1:0] op1_abs, op2_abs, add_sum, sub_diff;
  logic             add_ovf, sub_ovf;

  assign op_in    = op_e'(bus.alu_control);
  assign op1_abs  = bus.op1[WIDTH-1] ? -bus.op1 : bus.op1;
  assign op2_abs  = bus.op2[WIDTH-1] ? -bus.op2 : bus.op2;
  assign add_sum  = bus.op1 + bus.op2;
  assign sub_diff = bus.op1 - bus.op2;
  assign add_ovf  = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (add_sum[WIDTH-1] != bus.op1[WIDTH-1]);
  assign sub_ovf  = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.op1[WIDTH-1]);

  // One iteration step for each algorithm, plus the sign-corrected final values
  // used on the last CALC edge.
  logic [W2-1:0]    mul_acc_nx, mul_prod;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx, div_quo, div_rem;

  assign mul_acc_nx = y_q[0] ? acc_q + x_q : acc_q;
  assign mul_prod   = neg_quo_q ? -mul_acc_nx : mul_acc_nx;
  assign div_shift  = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, y_q};
  assign div_quo_nx = {x_q[WIDTH-2:0], ~div_trial[WIDTH]};
  assign div_rem_nx = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_quo    = neg_quo_q ? -div_quo_nx : div_quo_nx;
  assign div_rem    = neg_rem_q ? -div_rem_nx : div_rem_nx;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_mul_d   = is_mul_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    acc_d      = acc_q;
    x_d        = x_q;
    y_d        = y_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = DONE;
          case (op_in)
            OP_ADD: begin
              result_d   = {{WIDTH{1'b0}}, add_sum};
              overflow_d = add_ovf;
            end
            OP_SUB: begin
              result_d   = {{WIDTH{1'b0}}, sub_diff};
              overflow_d = sub_ovf;
            end
            OP_MOVE: begin
              result_d   = {{WIDTH{1'b0}}, bus.op2};
              overflow_d = 1'b0;
            end
            OP_SWAP: begin
              result_d   = {bus.op1, bus.op2};
              overflow_d = 1'b0;
            end
            OP_AND: begin
              result_d   = {{WIDTH{1'b0}}, bus.op1 & bus.op2};
              overflow_d = 1'b0;
            end
            OP_OR: begin
              result_d   = {{WIDTH{1'b0}}, bus.op1 | bus.op2};
              overflow_d = 1'b0;
            end
            OP_MUL, OP_DIV: begin
              if (op_in == OP_DIV && bus.op2 == '0) begin
                result_d   = {bus.op1, {WIDTH{1'b1}}};
                overflow_d = 1'b1;
              end else begin
                state_d   = CALC;
                cnt_d     = CNT_W'(WIDTH);
                is_mul_d  = (op_in == OP_MUL);
                neg_quo_d = bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1];
                neg_rem_d = bus.op1[WIDTH-1];
                acc_d     = '0;
                x_d       = {{WIDTH{1'b0}}, op1_abs};
                y_d       = op2_abs;
              end
            end
          endcase
        end
      end

      CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (is_mul_q) begin
          acc_d = mul_acc_nx;
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
        end else begin
          acc_d = {{WIDTH{1'b0}}, div_rem_nx};
          x_d   = {{WIDTH{1'b0}}, div_quo_nx};
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          if (is_mul_q) begin
            result_d   = mul_prod;
            overflow_d = (mul_prod[W2-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}});
          end else begin
            result_d   = {div_rem, div_quo};
            // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
            overflow_d = ~neg_quo_q & div_quo_nx[WIDTH-1];
          end
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_mul_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      acc_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_mul_q   <= is_mul_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      y_q        <= y_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
endmodule
